// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame size and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned DATA_BITS = 8;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the metastable first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with a one-entry hold register on a valid/ready interface.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 28_500_000,
  parameter int unsigned BAUD        = 115_200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  // Too few cycles per bit leaves no room for a mid-bit sample point.
  if (CLKS_PER_BIT < 4) begin : g_bad_divisor
    $error("uart_rx_8n1: CLKS_PER_BIT must be >= 4");
  end

  logic rx_s;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 byte_done_c;

  // Next-state: frame sequencing, then hold-register update on byte completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;
    byte_done_c = 1'b0;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_done_c = 1'b1;
            state_d     = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load wins over a same-cycle consume; a full, unconsumed register drops the byte.
    if (byte_done_c) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at 10 clocks per bit.
module tb_uart_rx_8n1;

  localparam int unsigned BIT_CLKS = 10;

  logic       clk;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  uart_rx_8n1 #(
    .CLK_FREQ_HZ (1_000_000),
    .BAUD        (100_000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Free-running cycle count and output event monitor, sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned valid_cycles = 0;
  int unsigned valid_rises = 0;
  int unsigned last_rise_cyc = 0;
  int unsigned ovr_cnt = 0;
  int unsigned ferr_cnt = 0;
  logic [7:0]  last_data = 8'h00;
  logic        valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) begin
        valid_cycles = valid_cycles + 1;
        last_data    = data_o;
        if (!valid_prev) begin
          valid_rises   = valid_rises + 1;
          last_rise_cyc = cyc;
        end
      end
      if (overrun_o)   ovr_cnt  = ovr_cnt + 1;
      if (frame_err_o) ferr_cnt = ferr_cnt + 1;
      valid_prev = valid_o;
    end else begin
      valid_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait n rising edges, then step 2 ns past the edge to drive.
  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Drive one frame starting now; caller is 2 ns after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = bits[i];
      cycles(BIT_CLKS);
    end
  endtask

  int unsigned start_cyc;
  int unsigned rises0, vcyc0, ovr0, ferr0;
  int          lat;

  initial begin
    rx_i    = 1'b1;
    ready_i = 1'b0;
    rst_n   = 1'b0;
    #23;
    check("reset_data",  int'(data_o), 0);
    check("reset_valid", int'(valid_o), 0);
    check("reset_ferr",  int'(frame_err_o), 0);
    check("reset_ovr",   int'(overrun_o), 0);
    check("reset_busy",  int'(busy_o), 0);
    rst_n = 1'b1;
    cycles(5);

    // Normal frame with the consumer always ready.
    ready_i   = 1'b1;
    rises0    = valid_rises;
    vcyc0     = valid_cycles;
    ovr0      = ovr_cnt;
    ferr0     = ferr_cnt;
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    cycles(20);
    lat = int'(last_rise_cyc) - int'(start_cyc);
    check("a5_data",    int'(last_data), 8'hA5);
    check("a5_rises",   int'(valid_rises - rises0), 1);
    check("a5_vcycles", int'(valid_cycles - vcyc0), 1);
    check("a5_latency", int'(lat >= 97 && lat <= 99), 1);
    check("a5_noerr",   int'((ovr_cnt - ovr0) + (ferr_cnt - ferr0)), 0);

    // Back-pressure: second byte overruns the full hold register.
    ready_i = 1'b0;
    ovr0    = ovr_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    cycles(10);
    check("ovr_data",  int'(data_o), 8'h3C);
    check("ovr_valid", int'(valid_o), 1);
    check("ovr_pulse", int'(ovr_cnt - ovr0), 1);
    ready_i = 1'b1;
    cycles(1);
    ready_i = 1'b0;
    @(negedge clk);
    check("ovr_drain", int'(valid_o), 0);
    cycles(3);

    // Consume-and-load on the exact completion cycle.
    send_frame(8'h11, 1'b1);
    cycles(10);
    check("hold_11", int'(data_o), 8'h11);
    rises0 = valid_rises;
    ovr0   = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        cycles(97);
        ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
      end
    join
    cycles(5);
    check("cl_valid", int'(valid_o), 1);
    check("cl_data",  int'(data_o), 8'h22);
    check("cl_noovr", int'(ovr_cnt - ovr0), 0);
    check("cl_norise", int'(valid_rises - rises0), 0);
    ready_i = 1'b1;
    cycles(3);

    // Framing error followed by a long break.
    rises0 = valid_rises;
    ferr0  = ferr_cnt;
    send_frame(8'h55, 1'b0);
    cycles(50 * BIT_CLKS);
    check("brk_busy", int'(busy_o), 1);
    rx_i = 1'b1;
    cycles(6);
    check("brk_idle",  int'(busy_o), 0);
    check("brk_ferr",  int'(ferr_cnt - ferr0), 1);
    check("brk_novld", int'(valid_rises - rises0), 0);
    cycles(10);
    send_frame(8'h0F, 1'b1);
    cycles(10);
    check("post_brk_data",  int'(last_data), 8'h0F);
    check("post_brk_rises", int'(valid_rises - rises0), 1);

    // Short glitch is rejected at the mid-start sample.
    rises0 = valid_rises;
    rx_i = 1'b0;
    cycles(3);
    rx_i = 1'b1;
    cycles(2);
    check("gl_busy", int'(busy_o), 1);
    cycles(7);
    check("gl_idle",  int'(busy_o), 0);
    check("gl_novld", int'(valid_rises - rises0), 0);

    // Reset in the middle of bit 4 of a frame.
    rx_i = 1'b0;
    cycles(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx_i = 1'b1;
      cycles(BIT_CLKS);
    end
    rx_i = 1'b0;
    cycles(5);
    check("mid_busy", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    check("rst_data", int'(data_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_valid", int'(valid_o), 0);
    rx_i = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    rises0 = valid_rises;
    send_frame(8'h81, 1'b1);
    cycles(10);
    check("post_rst_data",  int'(last_data), 8'h81);
    check("post_rst_rises", int'(valid_rises - rises0), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- Receives 8N1 asynchronous serial data from the board RX pin on the PLL-derived system clock.
- Presents each received byte on a valid/ready interface to the ALU command parser.
- Sits directly downstream of the board wrapper's rx_i pin, as the first stage inside the top-level design.
- Reports framing errors and overruns as single-cycle pulses for the status/LED logic.

Parameters:
- CLK_FREQ_HZ, 28_500_000, system clock frequency in Hz (PLL output).
- BAUD, 115_200, line rate in bit/s.
- CLKS_PER_BIT, (CLK_FREQ_HZ + BAUD/2) / BAUD, derived; cycles per bit, rounded to nearest integer. Must be >= 4; elaboration error otherwise.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_i  input  1  raw serial line; idle high; asynchronous to clk.
- data_o  output  8  received byte, LSB first on the wire.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: new byte completed while the hold register was full and not being consumed.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, rst_n low): synchronizer flops = 1, state = IDLE, data_o = 0, valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0, all counters = 0.
- rx_i passes through a 2-flop synchronizer; rx_s below is its output (2-cycle latency).
- Bit counter cnt counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2, truncating division.
- IDLE: when rx_s = 0, go to START with cnt = 0.
- START: when cnt = HALF-1, sample rx_s. If 0, go to DATA with cnt = 0 and bit index = 0. If 1, the start was a glitch; go to IDLE with no flag.
- DATA: when cnt = CLKS_PER_BIT-1, sample rx_s into shift[bit index] and reset cnt. After bit 7 is sampled, go to STOP.
- STOP: when cnt = CLKS_PER_BIT-1, sample rx_s.
  - If 1: the byte completes; go to IDLE.
  - If 0: pulse frame_err_o for one cycle, discard the byte, go to BREAK.
- BREAK: stay until rx_s = 1, then go to IDLE. A continuous low line produces exactly one frame_err_o pulse.
- Hold register, evaluated on the cycle a byte completes:
  - valid_o = 0: load data_o; valid_o = 1 on the next cycle.
  - valid_o = 1 and ready_i = 1: this is a simultaneous consume-and-load. Load the new byte, valid_o stays 1, no overrun.
  - valid_o = 1 and ready_i = 0: keep the old byte, drop the new one, pulse overrun_o for one cycle.
- Handshake rules:
  - valid_o && ready_i with no completing byte clears valid_o on the next cycle.
  - data_o is stable while valid_o = 1 and not accepted.
  - ready_i is ignored when valid_o = 0.
- Latency: valid_o rises 1 cycle after the mid-stop-bit sample, about 9.5 bit times plus 3 cycles after the start edge at rx_i.
- rst_n asserted mid-frame aborts immediately to the reset values. After release, reception restarts only on the next falling edge seen in IDLE. A partial frame already on the wire can mis-frame; that is acceptable.
- The receiver never blocks: it always receives the next frame, even while the hold register is full.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - Function clks_per_bit(freq, baud).
  - Constant DATA_BITS = 8, shared with the future uart_tx.
- Sub-module sync_2ff (width-1 synchronizer, async active-low reset to a parameterized value, here 1). It is reused later for the button input.

Test Plan:
- Sim parameters: CLK_FREQ_HZ = 1_000_000, BAUD = 100_000, giving CLKS_PER_BIT = 10 and HALF = 5.
- Normal frame: send 0xA5 with ready_i held 1 -> data_o = 0xA5, valid_o high for exactly 1 cycle, 98 ±1 cycles after the start edge; no error pulses.
- Back-pressure/overrun: send 0x3C then 0xC3 with ready_i = 0 -> data_o stays 0x3C, one overrun_o pulse at the 0xC3 completion; raising ready_i afterwards clears valid_o.
- Simultaneous consume and load: hold 0x11; assert ready_i exactly on the cycle 0x22 completes -> valid_o stays 1, data_o = 0x22, no overrun_o.
- Framing error/break: send 0x55 with stop bit 0, then hold the line low 50 bit times -> one frame_err_o pulse, no valid_o, busy_o high until the line returns high; a following 0x0F is received correctly.
- Glitch rejection and reset: a 3-cycle low pulse on rx_i -> no valid_o, busy_o falls after about 5 cycles. Assert rst_n low during bit 4 of a frame -> all outputs 0 at once; next full frame 0x81 is received correctly.
